// File: rtl/dvs_ravens_pkg.sv
// Shared types for the dvs_ravens event path.
// DVS_TIMESTAMP_EN adds a timestamp field to dvs_event_t.
package dvs_ravens_pkg;

    localparam int unsigned AER_W          = 10;
    localparam int unsigned FIFO_DEPTH_DEF = 8;
    localparam int unsigned DVS_X_W        = 9;
    localparam int unsigned DVS_Y_W        = 9;
    localparam int unsigned DVS_TS_W       = 32;

    typedef enum logic {
        NoRow,
        RowValid
    } asm_state_e;

    // Field order matches the FIFO entry packing in dvs_event_assembler.
    typedef struct packed {
        logic [DVS_X_W-1:0]  x;
        logic [DVS_Y_W-1:0]  y;
        logic                pol;
`ifdef DVS_TIMESTAMP_EN
        logic [DVS_TS_W-1:0] ts;
`endif
    } dvs_event_t;

endpackage

// File: rtl/dvs_event_fifo.sv
// Generic synchronous show-ahead FIFO; head entry is visible on rdata while !empty.
// Full is judged on start-of-cycle occupancy, so a push while full is lost even with a pop.
module dvs_event_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FullCnt);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dvs_event_assembler.sv
// Pairs AER row words with following column words into (x, y, pol) events and buffers them.
// Define DVS_TIMESTAMP_EN to add a free-running timestamp captured with each event (evt_ts).
module dvs_event_assembler
    import dvs_ravens_pkg::*;
#(
    parameter int unsigned X_W        = 9,
    parameter int unsigned Y_W        = 9,
    parameter int unsigned X_MAX      = 345,
    parameter int unsigned Y_MAX      = 259,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TS_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [AER_W-1:0] aer_rx,
    input  logic             xsel_rx,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [X_W-1:0]   evt_x,
    output logic [Y_W-1:0]   evt_y,
    output logic             evt_pol,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef DVS_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]  evt_ts
`endif
);

    localparam logic [X_W-1:0] XMaxV = X_W'(X_MAX);
    localparam logic [Y_W-1:0] YMaxV = Y_W'(Y_MAX);

    typedef struct packed {
        logic [X_W-1:0]  x;
        logic [Y_W-1:0]  y;
        logic            pol;
`ifdef DVS_TIMESTAMP_EN
        logic [TS_W-1:0] ts;
`endif
    } entry_t;

    asm_state_e          state_q, state_d;
    logic [Y_W-1:0]      row_q, row_d;
    logic [CNT_W-1:0]    ovf_q, ovf_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic                err_inc, ovf_inc, push_evt;
    logic                fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
    entry_t              wr_entry, head;

    logic [Y_W-1:0] rx_row;
    logic [X_W-1:0] rx_col;
    logic           row_ok, col_ok;

    assign rx_row = aer_rx[Y_W-1:0];
    assign rx_col = aer_rx[X_W:1];
    assign row_ok = (rx_row <= YMaxV);
    assign col_ok = (rx_col <= XMaxV);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        err_inc  = 1'b0;
        ovf_inc  = 1'b0;
        push_evt = 1'b0;
        if (rx_valid) begin
            unique case (state_q)
                NoRow: begin
                    if (!xsel_rx && row_ok) begin
                        row_d   = rx_row;
                        state_d = RowValid;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                RowValid: begin
                    if (!xsel_rx) begin
                        if (row_ok) begin
                            row_d = rx_row;
                        end else begin
                            err_inc = 1'b1;
                            state_d = NoRow;
                        end
                    end else if (!col_ok) begin
                        err_inc = 1'b1;
                    end else if (fifo_full) begin
                        ovf_inc = 1'b1;
                    end else begin
                        push_evt = 1'b1;
                    end
                end
                default: state_d = NoRow;
            endcase
        end
        // Saturating drop counters
        err_d = (err_inc && (err_q != '1)) ? err_q + CNT_W'(1) : err_q;
        ovf_d = (ovf_inc && (ovf_q != '1)) ? ovf_q + CNT_W'(1) : ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NoRow;
            row_q   <= '0;
            ovf_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

`ifdef DVS_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    assign ts_d = ts_q + TS_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wr_entry.ts = ts_q;
    assign evt_ts      = head.ts;
`endif

    assign wr_entry.x   = rx_col;
    assign wr_entry.y   = row_q;
    assign wr_entry.pol = aer_rx[0];

    dvs_event_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_evt),
        .wdata (wr_entry),
        .pop   (evt_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    assign evt_valid = !fifo_empty;
    assign evt_x     = head.x;
    assign evt_y     = head.y;
    assign evt_pol   = head.pol;
    assign ovf_cnt   = ovf_q;
    assign err_cnt   = err_q;

endmodule
